// File: rtl/sram_nrmw_regfile.sv
// Multi-read/multi-write register file with post-reset clear sequencer; SRAM_RD_BYPASS_EN selects write-first reads.
// Latency: 1 cycle read, 1 cycle write, SRAM_DEPTH-cycle clear after reset; conflict/oob flags 1 cycle late.
// Backpressure: none; accesses during the clear are dropped and init_done_o marks readiness.
module sram_nrmw_regfile #(
   parameter int SRAM_DEPTH = 32,
   parameter int SRAM_INDEX = 5,
   parameter int SRAM_WIDTH = 32,
   parameter int NUM_RD     = 12,
   parameter int NUM_WR     = 6
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_RD-1:0]              rd_en_i,
   input  logic [NUM_RD*SRAM_INDEX-1:0]   addr_rd_i,
   input  logic [NUM_WR-1:0]              we_i,
   input  logic [NUM_WR*SRAM_INDEX-1:0]   addr_wr_i,
   input  logic [NUM_WR*SRAM_WIDTH-1:0]   data_wr_i,
   output logic [NUM_RD*SRAM_WIDTH-1:0]   data_o,
   output logic [NUM_RD*SRAM_DEPTH-1:0]   decoded_rd_o,
   output logic [NUM_WR*SRAM_DEPTH-1:0]   decoded_wr_o,
   output logic                           init_done_o,
   output logic                           conflict_o,
   output logic                           oob_o
);

   localparam logic [31:0] DEPTH_U = SRAM_DEPTH;

   typedef enum logic {CLEAR, READY} state_t;

   state_t                  state_q, state_d;
   logic [SRAM_INDEX-1:0]   clr_cnt_q;
   logic                    clr_last;
   logic                    clr_we;
   logic [SRAM_WIDTH-1:0]   sram [SRAM_DEPTH];

   logic [SRAM_INDEX-1:0]   rd_addr [NUM_RD];
   logic [SRAM_INDEX-1:0]   wr_addr [NUM_WR];
   logic [SRAM_WIDTH-1:0]   wr_data [NUM_WR];
   logic [NUM_RD-1:0]       rd_ok;
   logic [NUM_WR-1:0]       wr_ok;
   logic [SRAM_WIDTH-1:0]   rd_val [NUM_RD];
   logic                    conflict_d;
   logic                    oob_d;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      assign rd_addr[p] = addr_rd_i[p*SRAM_INDEX +: SRAM_INDEX];
      assign rd_ok[p]   = 32'(rd_addr[p]) < DEPTH_U;
   end

   for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
      assign wr_addr[w] = addr_wr_i[w*SRAM_INDEX +: SRAM_INDEX];
      assign wr_data[w] = data_wr_i[w*SRAM_WIDTH +: SRAM_WIDTH];
      assign wr_ok[w]   = 32'(wr_addr[w]) < DEPTH_U;
   end

   // Out-of-range addresses match no entry, so their decode rows stay zero.
   always_comb begin
      decoded_rd_o = '0;
      decoded_wr_o = '0;
      for (int p = 0; p < NUM_RD; p++)
         for (int e = 0; e < SRAM_DEPTH; e++)
            decoded_rd_o[p*SRAM_DEPTH + e] = (rd_addr[p] == SRAM_INDEX'(e));
      for (int w = 0; w < NUM_WR; w++)
         for (int e = 0; e < SRAM_DEPTH; e++)
            decoded_wr_o[w*SRAM_DEPTH + e] = we_i[w] && (wr_addr[w] == SRAM_INDEX'(e));
   end

   always_comb begin
      conflict_d = 1'b0;
      oob_d      = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         if (we_i[i] && !wr_ok[i])
            oob_d = 1'b1;
         for (int j = i + 1; j < NUM_WR; j++)
            if (we_i[i] && we_i[j] && (wr_addr[i] == wr_addr[j]))
               conflict_d = 1'b1;
      end
      for (int p = 0; p < NUM_RD; p++)
         if (rd_en_i[p] && !rd_ok[p])
            oob_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset)
         state_q <= CLEAR;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEAR:   if (clr_last) state_d = READY;
         READY:   state_d = READY;
         default: state_d = CLEAR;
      endcase
   end

   always_comb begin
      init_done_o = (state_q == READY);
      clr_we      = (state_q == CLEAR);
   end

   assign clr_last = (clr_cnt_q == SRAM_INDEX'(SRAM_DEPTH - 1));

   always_ff @(posedge clk) begin
      if (!reset)
         clr_cnt_q <= '0;
      else if (clr_we)
         clr_cnt_q <= clr_cnt_q + 1'b1;
   end

   // Ascending port order: the last assignment (highest port) wins on a shared address.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (clr_we)
            sram[clr_cnt_q] <= '0;
         else
            for (int w = 0; w < NUM_WR; w++)
               if (we_i[w] && wr_ok[w])
                  sram[wr_addr[w]] <= wr_data[w];
      end
   end

`ifdef SRAM_RD_BYPASS_EN
   logic [NUM_RD-1:0]       byp_hit;
   logic [SRAM_WIDTH-1:0]   byp_dat [NUM_RD];

   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         byp_hit[p] = 1'b0;
         byp_dat[p] = '0;
         for (int w = 0; w < NUM_WR; w++)
            if (we_i[w] && wr_ok[w] && (wr_addr[w] == rd_addr[p])) begin
               byp_hit[p] = 1'b1;
               byp_dat[p] = wr_data[w];
            end
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         rd_val[p] = rd_ok[p] ? sram[rd_addr[p]] : '0;
         if (byp_hit[p])
            rd_val[p] = byp_dat[p];
      end
   end
`else
   always_comb begin
      for (int p = 0; p < NUM_RD; p++)
         rd_val[p] = rd_ok[p] ? sram[rd_addr[p]] : '0;
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset || clr_we) begin
         data_o     <= '0;
         conflict_o <= 1'b0;
         oob_o      <= 1'b0;
      end else begin
         for (int p = 0; p < NUM_RD; p++)
            if (rd_en_i[p])
               data_o[p*SRAM_WIDTH +: SRAM_WIDTH] <= rd_val[p];
         conflict_o <= conflict_d;
         oob_o      <= oob_d;
      end
   end

endmodule

// File: tb/tb_sram_nrmw_regfile.sv
// Bench for sram_nrmw_regfile: a 32-entry and a 24-entry instance share stimulus and are
// compared every cycle against an array-based model, plus directed checks.
module tb_sram_nrmw_regfile;
   localparam int NR = 12;
   localparam int NW = 6;
   localparam int W  = 32;
   localparam int IX = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic [NR-1:0]    rd_en;
   logic [NR*IX-1:0] addr_rd;
   logic [NW-1:0]    we;
   logic [NW*IX-1:0] addr_wr;
   logic [NW*W-1:0]  data_wr;

   logic [NR*W-1:0]  a_dat, b_dat;
   logic [NR*32-1:0] a_drd;
   logic [NR*24-1:0] b_drd;
   logic [NW*32-1:0] a_dwr;
   logic [NW*24-1:0] b_dwr;
   logic a_init, b_init, a_conf, b_conf, a_oob, b_oob;

   sram_nrmw_regfile u_a (
      .clk(clk), .reset(reset), .rd_en_i(rd_en), .addr_rd_i(addr_rd), .we_i(we),
      .addr_wr_i(addr_wr), .data_wr_i(data_wr), .data_o(a_dat), .decoded_rd_o(a_drd),
      .decoded_wr_o(a_dwr), .init_done_o(a_init), .conflict_o(a_conf), .oob_o(a_oob));

   sram_nrmw_regfile #(.SRAM_DEPTH(24)) u_b (
      .clk(clk), .reset(reset), .rd_en_i(rd_en), .addr_rd_i(addr_rd), .we_i(we),
      .addr_wr_i(addr_wr), .data_wr_i(data_wr), .data_o(b_dat), .decoded_rd_o(b_drd),
      .decoded_wr_o(b_dwr), .init_done_o(b_init), .conflict_o(b_conf), .oob_o(b_oob));

   int tests = 0;
   int fails = 0;

   // Reference model: one plain array per instance and a count of entries still to clear.
   int          dep [2] = '{32, 24};
   logic [31:0] mem [2][32];
   logic [31:0] eq  [2][NR];
   logic        ec  [2];
   logic        eo  [2];
   int          clr_left [2] = '{0, 0};

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [IX-1:0] ra(input int p);
      return addr_rd[p*IX +: IX];
   endfunction

   function automatic logic [IX-1:0] wa(input int w);
      return addr_wr[w*IX +: IX];
   endfunction

   function automatic logic [W-1:0] wd(input int w);
      return data_wr[w*W +: W];
   endfunction

   task automatic model_edge();
      logic [31:0] val;
      int a;
      logic c, o;
      for (int k = 0; k < 2; k++) begin
         if (!reset) begin
            clr_left[k] = dep[k];
            for (int p = 0; p < NR; p++) eq[k][p] = '0;
            ec[k] = 1'b0;
            eo[k] = 1'b0;
         end else if (clr_left[k] > 0) begin
            mem[k][dep[k] - clr_left[k]] = '0;
            clr_left[k]--;
            for (int p = 0; p < NR; p++) eq[k][p] = '0;
            ec[k] = 1'b0;
            eo[k] = 1'b0;
         end else begin
            c = 1'b0;
            o = 1'b0;
            for (int w = 0; w < NW; w++) begin
               if (we[w] && int'(wa(w)) >= dep[k]) o = 1'b1;
               for (int v = w + 1; v < NW; v++)
                  if (we[w] && we[v] && wa(w) == wa(v)) c = 1'b1;
            end
            for (int p = 0; p < NR; p++) begin
               if (rd_en[p]) begin
                  a = int'(ra(p));
                  if (a >= dep[k]) begin
                     o = 1'b1;
                     eq[k][p] = '0;
                  end else begin
                     val = mem[k][a];
`ifdef SRAM_RD_BYPASS_EN
                     for (int w = 0; w < NW; w++)
                        if (we[w] && int'(wa(w)) == a) val = wd(w);
`endif
                     eq[k][p] = val;
                  end
               end
            end
            for (int w = 0; w < NW; w++)
               if (we[w] && int'(wa(w)) < dep[k]) mem[k][int'(wa(w))] = wd(w);
            ec[k] = c;
            eo[k] = o;
         end
      end
   endtask

   task automatic check_dec();
      logic [NR*32-1:0] ea;
      logic [NR*24-1:0] eb;
      logic [NW*32-1:0] xa;
      logic [NW*24-1:0] xb;
      int a;
      ea = '0; eb = '0; xa = '0; xb = '0;
      for (int p = 0; p < NR; p++) begin
         a = int'(ra(p));
         ea[p*32 + a] = 1'b1;
         if (a < 24) eb[p*24 + a] = 1'b1;
      end
      for (int w = 0; w < NW; w++) begin
         a = int'(wa(w));
         if (we[w]) begin
            xa[w*32 + a] = 1'b1;
            if (a < 24) xb[w*24 + a] = 1'b1;
         end
      end
      chk("a_dec_rd", 512'(a_drd), 512'(ea));
      chk("b_dec_rd", 512'(b_drd), 512'(eb));
      chk("a_dec_wr", 512'(a_dwr), 512'(xa));
      chk("b_dec_wr", 512'(b_dwr), 512'(xb));
   endtask

   task automatic check_regs();
      logic [NR*W-1:0] ev [2];
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < NR; p++) ev[k][p*W +: W] = eq[k][p];
      chk("a_data", 512'(a_dat), 512'(ev[0]));
      chk("b_data", 512'(b_dat), 512'(ev[1]));
      chk("a_init", 512'(a_init), 512'(clr_left[0] == 0));
      chk("b_init", 512'(b_init), 512'(clr_left[1] == 0));
      chk("a_conflict", 512'(a_conf), 512'(ec[0]));
      chk("b_conflict", 512'(b_conf), 512'(ec[1]));
      chk("a_oob", 512'(a_oob), 512'(eo[0]));
      chk("b_oob", 512'(b_oob), 512'(eo[1]));
   endtask

   task automatic cycle();
      #1;
      check_dec();
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
   endtask

   task automatic idle();
      rd_en = '0; we = '0; addr_rd = '0; addr_wr = '0; data_wr = '0;
   endtask

   task automatic rd(input int p, input int a);
      rd_en[p] = 1'b1;
      addr_rd[p*IX +: IX] = IX'(a);
   endtask

   task automatic wr(input int w, input int a, input logic [31:0] d);
      we[w] = 1'b1;
      addr_wr[w*IX +: IX] = IX'(a);
      data_wr[w*W +: W] = d;
   endtask

   initial begin
      int cnt;
      reset = 1'b0;
      idle();
      cycle();
      cycle();
      reset = 1'b1;
      cnt = 0;
      do begin cycle(); cnt++; end while (!a_init && cnt < 100);
      chk("init_first_cycles", 512'(cnt), 512'(32));

      for (int e = 0; e < NW; e++) wr(e, e + 1, $urandom);
      cycle();
      idle();

      // Clear after a 1-cycle reset, with a write injected while entry 7 is already cleared.
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      cnt = 0;
      do begin
         idle();
         if (cnt == 28) wr(0, 7, 32'h1234_5678);
         cycle();
         cnt++;
      end while (!a_init && cnt < 100);
      chk("init_after_reset_cycles", 512'(cnt), 512'(32));
      idle();

      for (int base = 0; base < 32; base += NR) begin
         for (int p = 0; p < NR; p++) if (base + p < 32) rd(p, base + p);
         cycle();
         idle();
         chk("clear_reads_zero", 512'(a_dat), 512'(0));
      end

      wr(0, 5, 32'hDEAD_BEEF);
      cycle();
      idle();
      rd(11, 5);
      cycle();
      chk("basic_rw", 512'(a_dat[11*W +: W]), 512'(32'hDEAD_BEEF));
      idle();
      cycle();
      chk("hold_no_rden", 512'(a_dat[11*W +: W]), 512'(32'hDEAD_BEEF));

      wr(1, 9, 32'h11);
      wr(4, 9, 32'h44);
      cycle();
      chk("conflict_set", 512'(a_conf), 512'(1));
      idle();
      rd(0, 9);
      cycle();
      chk("conflict_clear", 512'(a_conf), 512'(0));
      chk("priority_data", 512'(a_dat[0 +: W]), 512'(32'h44));

      idle();
      wr(2, 3, 32'hA5A5_A5A5);
      rd(0, 3);
      cycle();
`ifdef SRAM_RD_BYPASS_EN
      chk("same_edge_rw", 512'(a_dat[0 +: W]), 512'(32'hA5A5_A5A5));
`else
      chk("same_edge_rw", 512'(a_dat[0 +: W]), 512'(0));
`endif
      idle();
      rd(0, 3);
      cycle();
      chk("after_same_edge", 512'(a_dat[0 +: W]), 512'(32'hA5A5_A5A5));

      idle();
      rd(2, 5);
      cycle();
      chk("b_pre_oob", 512'(b_dat[2*W +: W]), 512'(32'hDEAD_BEEF));
      idle();
      rd(2, 30);
      #1;
      chk("b_oob_decode", 512'(b_drd[2*24 +: 24]), 512'(0));
      cycle();
      chk("b_oob_data", 512'(b_dat[2*W +: W]), 512'(0));
      chk("b_oob_flag", 512'(b_oob), 512'(1));
      chk("a_no_oob", 512'(a_oob), 512'(0));
      idle();
      cycle();
      chk("b_oob_clear", 512'(b_oob), 512'(0));
      chk("a_hold_30", 512'(a_dat[2*W +: W]), 512'(eq[0][2]));

      // Reset again while the clear is at entry 10.
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      cnt = 0;
      do begin cycle(); cnt++; end while (!a_init && cnt < 100);
      chk("init_mid_clear_cycles", 512'(cnt), 512'(32));

      for (int n = 0; n < 400; n++) begin
         idle();
         for (int p = 0; p < NR; p++)
            if ($urandom_range(0, 1) == 1) rd(p, (n % 2 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3)));
         for (int w = 0; w < NW; w++)
            if ($urandom_range(0, 2) == 0) wr(w, (n % 3 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31)), $urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
